pc_fetch_unit: RTL and testbench

- Program-counter and fetch-control stage that sits directly upstream of the instruction memory.
- Drives the word-aligned byte address that the instruction memory divides by 4.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Runs a small boot/run/halt state machine and traps fetch-address faults before an illegal address reaches memory.

---
 rtl/pc_fetch_unit.sv | 133 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch-control stage in front of the instruction memory.
// Picks the next PC (sequential / branch / jump / jump-register), runs a
// BOOT -> RUN -> HALT sequence, and halts before an illegal fetch address
// can reach memory.
module pc_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int RESET_ADDR = 0,
  parameter int IMEM_DEPTH = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jump_reg,
  input  logic [ADDR_WIDTH-1:0] jr_target,
  input  logic                  halt_req,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_valid,
  output logic                  halted,
  output logic                  addr_fault,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // First byte address past the end of instruction memory.
  localparam logic [ADDR_WIDTH-1:0] PC_LIMIT  = ADDR_WIDTH'(IMEM_DEPTH * 4);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET  = ADDR_WIDTH'(RESET_ADDR);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
  logic                   fault_reg, fault_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;

  logic [ADDR_WIDTH-1:0]  candidate;
  logic                   candidate_fault;
  logic [CNT_WIDTH-1:0]   count_inc;

  assign pc_plus4 = pc_reg + ADDR_WIDTH'(4);

  // Next-PC candidate; jump-register beats jump beats branch beats sequential.
  always_comb begin
    candidate = pc_plus4;
    if (jump_reg) begin
      candidate = jr_target;
    end else if (jump) begin
      candidate = {pc_plus4[ADDR_WIDTH-1:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      candidate = pc_plus4 + (branch_offset << 2);
    end
  end

  // A target is illegal if misaligned or beyond the last memory word.
  always_comb begin
    candidate_fault = (candidate[1:0] != 2'b00) || (candidate >= PC_LIMIT);
  end

  // Retired counter sticks at its maximum instead of wrapping.
  always_comb begin
    count_inc = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;
  end

  // State, PC, fault flag and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= PC_RESET;
      fault_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic; only RUN reacts to the control inputs.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    count_next = count_reg;
    unique case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_next = HALT;
          fault_next = 1'b0;
        end else if (stall) begin
          state_next = RUN;
        end else if (candidate_fault) begin
          // PC keeps pointing at the instruction whose target was bad;
          // that instruction still counts as executed.
          state_next = HALT;
          fault_next = 1'b1;
          count_next = count_inc;
        end else begin
          pc_next    = candidate;
          count_next = count_inc;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    pc            = pc_reg;
    fetch_valid   = (state_reg == RUN);
    halted        = (state_reg == HALT);
    addr_fault    = fault_reg;
    retired_count = count_reg;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit, built with a 4-bit retired counter so
// saturation is reachable quickly.
module tb_pc_fetch_unit;

  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_offset;
  logic          jump;
  logic [25:0]   jump_index;
  logic          jump_reg;
  logic [AW-1:0] jr_target;
  logic          halt_req;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus4;
  logic          fetch_valid;
  logic          halted;
  logic          addr_fault;
  logic [CW-1:0] retired_count;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .ADDR_WIDTH(AW),
    .RESET_ADDR(0),
    .IMEM_DEPTH(9),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg),
    .jr_target    (jr_target),
    .halt_req     (halt_req),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .halted       (halted),
    .addr_fault   (addr_fault),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; branch_offset = '0; jump = 0;
    jump_index = '0; jump_reg = 0; jr_target = '0; halt_req = 0;
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and pass through BOOT so the unit is in RUN at pc=0.
  task automatic reset_to_run();
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic check_state(input string tag, input logic [31:0] epc,
                             input logic [31:0] ecnt, input logic ev,
                             input logic eh, input logic ef);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".cnt"}, 32'(retired_count), ecnt);
    check({tag, ".valid"}, 32'(fetch_valid), 32'(ev));
    check({tag, ".halted"}, 32'(halted), 32'(eh));
    check({tag, ".fault"}, 32'(addr_fault), 32'(ef));
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();

    // ---- reset values and BOOT cycle ----
    #12;
    check_state("reset", 0, 0, 0, 0, 0);
    check("reset.pc_plus4", pc_plus4, 32'd4);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("boot.valid", 32'(fetch_valid), 0);
    step();
    check_state("run0", 0, 0, 1, 0, 0);

    // ---- sequential fetch 0..32, then falling off the end faults ----
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("seq%0d.pc", i), pc, 32'(4 * i));
    end
    check("seq.cnt8", 32'(retired_count), 8);
    step();
    check_state("seq_end", 32, 9, 0, 1, 1);

    // ---- branches ----
    reset_to_run();
    step(); step();
    check("br.pre", pc, 8);
    branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
    step();
    check("br.back", pc, 4);
    clear_inputs();
    step();
    check("br.seq", pc, 8);
    branch_taken = 1; branch_offset = 32'd1;
    step();
    check_state("br.fwd", 16, 5, 1, 0, 0);

    // ---- jump register beats jump; jump alone ----
    clear_inputs();
    jump_reg = 1; jr_target = 4;
    step();
    check("jr.to4", pc, 4);
    jump = 1; jump_index = 26'd5; jump_reg = 1; jr_target = 12;
    step();
    check("jr.wins", pc, 12);
    jump_reg = 0;
    step();
    check_state("jmp", 20, 8, 1, 0, 0);

    // ---- stall holds everything, then halt_req with stall ----
    clear_inputs();
    jump_reg = 1; jr_target = 12;
    step();
    check("st.pre", pc, 12);
    clear_inputs();
    stall = 1; branch_taken = 1; branch_offset = 32'd1;
    step(); step(); step();
    check_state("stall3", 12, 9, 1, 0, 0);
    halt_req = 1;
    step();
    check_state("halt_req", 12, 9, 0, 1, 0);
    clear_inputs();
    jump_reg = 1; jr_target = 0;
    step(); step();
    check_state("halt_sticky", 12, 9, 0, 1, 0);

    // ---- misaligned JR target ----
    reset_to_run();
    step(); step(); step(); step();
    check("mis.pre", pc, 16);
    jump_reg = 1; jr_target = 32'h22;
    step();
    check_state("mis", 16, 5, 0, 1, 1);
    jr_target = 0;
    step();
    check_state("mis_sticky", 16, 5, 0, 1, 1);

    // ---- out-of-range JR target ----
    reset_to_run();
    step(); step(); step(); step();
    jump_reg = 1; jr_target = 36;
    step();
    check_state("oor", 16, 5, 0, 1, 1);
    jr_target = 8;
    step();
    check_state("oor_sticky", 16, 5, 0, 1, 1);

    // ---- counter saturation, then asynchronous reset between edges ----
    reset_to_run();
    jump_reg = 1; jr_target = 8;
    for (int i = 0; i < 20; i++) step();
    check_state("sat", 8, 15, 1, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check_state("async_rst", 0, 0, 0, 0, 0);
    rst_n = 1;
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
